// File: rtl/bb_phase_detector_if.sv
// Sample/correction bundle between the rotator sampler and the bang-bang phase detector.
// Optional PD_LOCK_EN adds the locked indicator.
interface bb_phase_detector_if #(
  parameter int CNT_W = 5
);
  logic             sample_valid;
  logic             s_early;
  logic             s_edge;
  logic             s_late;
  logic             inc;
  logic             dec;
  logic [CNT_W-1:0] acc;
`ifdef PD_LOCK_EN
  logic             locked;
`endif

  modport master (
    output sample_valid, s_early, s_edge, s_late,
    input  inc, dec, acc
`ifdef PD_LOCK_EN
    , input locked
`endif
  );

  modport slave (
    input  sample_valid, s_early, s_edge, s_late,
    output inc, dec, acc
`ifdef PD_LOCK_EN
    , output locked
`endif
  );
endinterface

// File: rtl/bb_phase_detector.sv
// Bang-bang phase detector with vote accumulator, registered inc/dec pulses and post-correction HOLD.
// Macro PD_LOCK_EN compiles in the alternation-based lock detector and the locked output.
module bb_phase_detector #(
  parameter int CNT_W   = 5,
  parameter int THRESH  = 8,
  parameter int HOLDOFF = 4
) (
  input  logic               clk,
  input  logic               rst,
  bb_phase_detector_if.slave pd
);

  typedef enum logic [0:0] {TRACK, HOLD} state_t;

  localparam logic signed [CNT_W:0] THR_P  = (CNT_W+1)'(THRESH);
  localparam logic signed [CNT_W:0] THR_N  = -(CNT_W+1)'(THRESH);
  localparam logic signed [CNT_W:0] VOTE_P = (CNT_W+1)'(1);
  localparam logic signed [CNT_W:0] VOTE_N = -(CNT_W+1)'(1);

  state_t                  state_q, state_d;
  logic signed [CNT_W-1:0] acc_q, acc_d;
  logic [3:0]              hold_q, hold_d;
  logic                    inc_q, inc_d;
  logic                    dec_q, dec_d;
  logic signed [CNT_W:0]   acc_ext;
  logic signed [CNT_W:0]   acc_next;
  logic signed [CNT_W:0]   vote;

  assign acc_ext = {acc_q[CNT_W-1], acc_q};

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    hold_d   = hold_q;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    vote     = '0;
    acc_next = acc_ext;

    if (pd.s_early != pd.s_late) begin
      vote = (pd.s_edge == pd.s_early) ? VOTE_P : VOTE_N;
    end

    case (state_q)
      TRACK: begin
        if (pd.sample_valid) begin
          acc_next = acc_ext + vote;
          if (acc_next == THR_P || acc_next == THR_N) begin
            acc_d   = '0;
            inc_d   = (acc_next == THR_P);
            dec_d   = (acc_next == THR_N);
            state_d = HOLD;
            hold_d  = 4'(HOLDOFF);
          end else begin
            acc_d = acc_next[CNT_W-1:0];
          end
        end
      end
      HOLD: begin
        // Counter hits zero on the edge that returns to TRACK.
        acc_d  = '0;
        hold_d = hold_q - 4'd1;
        if (hold_q == 4'd1) begin
          state_d = TRACK;
        end
      end
      default: state_d = TRACK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= TRACK;
      acc_q   <= '0;
      hold_q  <= '0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      hold_q  <= hold_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
    end
  end

  assign pd.inc = inc_q;
  assign pd.dec = dec_q;
  assign pd.acc = acc_q;

`ifdef PD_LOCK_EN
  logic       last_vld_q, last_vld_d;
  logic       last_dir_q, last_dir_d;
  logic [2:0] alt_q, alt_d;
  logic       locked_q, locked_d;

  always_comb begin
    last_vld_d = last_vld_q;
    last_dir_d = last_dir_q;
    alt_d      = alt_q;
    if (inc_d || dec_d) begin
      // The first correction after reset has nothing to alternate against.
      if (last_vld_q) begin
        if (inc_d != last_dir_q) begin
          alt_d = (alt_q == 3'd4) ? 3'd4 : alt_q + 3'd1;
        end else begin
          alt_d = 3'd0;
        end
      end
      last_vld_d = 1'b1;
      last_dir_d = inc_d;
    end
    locked_d = (alt_d == 3'd4);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      last_vld_q <= 1'b0;
      last_dir_q <= 1'b0;
      alt_q      <= 3'd0;
      locked_q   <= 1'b0;
    end else begin
      last_vld_q <= last_vld_d;
      last_dir_q <= last_dir_d;
      alt_q      <= alt_d;
      locked_q   <= locked_d;
    end
  end

  assign pd.locked = locked_q;
`endif

endmodule

// File: tb/tb_bb_phase_detector.sv
// Directed and random stimulus for bb_phase_detector, checked against a behavioural model.
module tb_bb_phase_detector;
  localparam int CNT_W   = 5;
  localparam int THRESH  = 8;
  localparam int HOLDOFF = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bb_phase_detector_if #(.CNT_W(CNT_W)) bus ();

  bb_phase_detector #(.CNT_W(CNT_W), .THRESH(THRESH), .HOLDOFF(HOLDOFF)) dut (
    .clk (clk),
    .rst (rst),
    .pd  (bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // Behavioural model: integer accumulator, remaining ignored cycles, history of corrections.
  int m_acc = 0;
  int m_hold = 0;
  int m_inc = 0;
  int m_dec = 0;
  int m_locked = 0;
  int dirs[$];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic e, input logic d, input logic l);
    int vote;
    int s;
    int n;
    m_inc = 0;
    m_dec = 0;
    if (!r) begin
      m_acc = 0;
      m_hold = 0;
      dirs.delete();
    end else if (m_hold > 0) begin
      m_hold--;
      m_acc = 0;
    end else if (v) begin
      vote = (e == l) ? 0 : ((d == e) ? 1 : -1);
      s = m_acc + vote;
      if (s == THRESH) begin
        m_acc = 0; m_inc = 1; m_hold = HOLDOFF; dirs.push_back(1);
      end else if (s == -THRESH) begin
        m_acc = 0; m_dec = 1; m_hold = HOLDOFF; dirs.push_back(-1);
      end else begin
        m_acc = s;
      end
    end
    // Locked when the last five corrections since reset strictly alternate.
    n = dirs.size();
    m_locked = (n >= 5) ? 1 : 0;
    for (int i = 0; i < 4 && n >= 5; i++) begin
      if (dirs[n-1-i] == dirs[n-2-i]) m_locked = 0;
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check on the falling edge.
  task automatic step(input logic r, input logic v, input logic e, input logic d, input logic l);
    logic signed [31:0] acc_obs;
    rst = r;
    bus.sample_valid = v;
    bus.s_early = e;
    bus.s_edge = d;
    bus.s_late = l;
    @(posedge clk);
    model_edge(r, v, e, d, l);
    @(negedge clk);
    acc_obs = $signed(bus.acc);
    chk("acc", acc_obs, m_acc);
    chk("inc", {31'd0, bus.inc}, m_inc);
    chk("dec", {31'd0, bus.dec}, m_dec);
`ifdef PD_LOCK_EN
    chk("locked", {31'd0, bus.locked}, m_locked);
`endif
  endtask

  task automatic rnd_step(input logic r);
    step(r, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Produce one correction: THRESH votes in the given direction, then ride out HOLD.
  task automatic correction(input bit up);
    for (int i = 0; i < THRESH; i++) begin
      if (up) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      else    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    end
    for (int i = 0; i < HOLDOFF; i++) rnd_step(1'b1);
  endtask

  initial begin
    logic signed [31:0] acc_obs;
    bus.sample_valid = 1'b0;
    bus.s_early = 1'b0;
    bus.s_edge = 1'b0;
    bus.s_late = 1'b0;
    @(negedge clk);

    // Reset with random samples, then explicit reset-state checks.
    for (int i = 0; i < 3; i++) rnd_step(1'b0);
    chk("rst_acc", {31'd0, |bus.acc}, 0);
    chk("rst_inc", {31'd0, bus.inc}, 0);
    chk("rst_dec", {31'd0, bus.dec}, 0);
`ifdef PD_LOCK_EN
    chk("rst_locked", {31'd0, bus.locked}, 0);
`endif

    // Late clock: acc -1..-7, dec on the 8th vote, 4 HOLD cycles, repeat.
    for (int rep = 0; rep < 2; rep++) begin
      for (int k = 1; k <= THRESH; k++) begin
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        acc_obs = $signed(bus.acc);
        if (k < THRESH) chk("late_acc", acc_obs, -k);
        else            chk("late_dec", {31'd0, bus.dec}, 1);
      end
      for (int i = 0; i < HOLDOFF; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    end

    // Early clock.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= THRESH + HOLDOFF + 3; k++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // No transitions: accumulator never moves.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (k[0]) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      else      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    acc_obs = $signed(bus.acc);
    chk("notrans_acc", acc_obs, 0);

    // Cancellation: 7 early, 7 late, 1 early -> +1.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    acc_obs = $signed(bus.acc);
    chk("cancel_acc", acc_obs, 1);

    // Reset two cycles into HOLD, then the first late vote gives -1.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < THRESH; k++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("hold_dec", {31'd0, bus.dec}, 1);
    rnd_step(1'b1);
    rnd_step(1'b1);
    rnd_step(1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    acc_obs = $signed(bus.acc);
    chk("postrst_acc", acc_obs, -1);

    // Alternating corrections then two same-direction incs.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    correction(1'b1);
    correction(1'b0);
    correction(1'b1);
    correction(1'b0);
    correction(1'b1);
    correction(1'b1);
    correction(1'b1);

    // Random traffic with occasional reset.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 2) != 0)
        step(($urandom_range(0, 199) != 0), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      else
        step(1'b1, 1'b1, 1'b1, 1'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
